// File: rtl/alu_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Opcode constants, controller state encoding and opcode legality
//           check shared by the ALU share controller.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'h0;
    localparam logic [3:0] ALU_OR    = 4'h1;
    localparam logic [3:0] ALU_ADD   = 4'h2;
    localparam logic [3:0] ALU_SUB   = 4'h6;
    localparam logic [3:0] ALU_PASSB = 4'h7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) ||
               (ctrl == ALU_SUB) || (ctrl == ALU_PASSB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_ctrl_if
// Brief   : Request/response channels for both requesters plus the shared
//           ALU bus and status of the ALU share controller.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_share_ctrl_if #(
    parameter int WIDTH = 64,
    parameter int CTRLW = 4
) ();

    logic             Req0Valid;
    logic             Req0Ready;
    logic [WIDTH-1:0] Req0A;
    logic [WIDTH-1:0] Req0B;
    logic [CTRLW-1:0] Req0Ctrl;
    logic             Rsp0Valid;
    logic             Rsp0Ready;
    logic [WIDTH-1:0] Rsp0W;
    logic             Rsp0Zero;
    logic             Rsp0Err;

    logic             Req1Valid;
    logic             Req1Ready;
    logic [WIDTH-1:0] Req1A;
    logic [WIDTH-1:0] Req1B;
    logic [CTRLW-1:0] Req1Ctrl;
    logic             Rsp1Valid;
    logic             Rsp1Ready;
    logic [WIDTH-1:0] Rsp1W;
    logic             Rsp1Zero;
    logic             Rsp1Err;

    logic [WIDTH-1:0] AluBusA;
    logic [WIDTH-1:0] AluBusB;
    logic [CTRLW-1:0] AluCtrl;
    logic [WIDTH-1:0] AluBusW;
    logic             AluZero;

    logic             Busy;
    logic             GrantId;

    // Controller side
    modport slave (
        input  Req0Valid, Req0A, Req0B, Req0Ctrl, Rsp0Ready,
        input  Req1Valid, Req1A, Req1B, Req1Ctrl, Rsp1Ready,
        input  AluBusW, AluZero,
        output Req0Ready, Rsp0Valid, Rsp0W, Rsp0Zero, Rsp0Err,
        output Req1Ready, Rsp1Valid, Rsp1W, Rsp1Zero, Rsp1Err,
        output AluBusA, AluBusB, AluCtrl, Busy, GrantId
    );

    // Requester / ALU side
    modport master (
        output Req0Valid, Req0A, Req0B, Req0Ctrl, Rsp0Ready,
        output Req1Valid, Req1A, Req1B, Req1Ctrl, Rsp1Ready,
        output AluBusW, AluZero,
        input  Req0Ready, Rsp0Valid, Rsp0W, Rsp0Zero, Rsp0Err,
        input  Req1Ready, Rsp1Valid, Rsp1W, Rsp1Zero, Rsp1Err,
        input  AluBusA, AluBusB, AluCtrl, Busy, GrantId
    );

endinterface
`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin arbiter; on a tie the requester that did not
//           win last time is granted.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = valid0 | valid1;
    assign grant_id    = (valid0 && valid1) ? ~last : valid1;

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_ctrl
// Brief   : Shares one combinational ALU between two requesters with an
//           issue / settle / held-response sequence per operation.
// Revision: 1.0 - initial release
// ============================================================================
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CTRLW = 4
) (
    input  logic            CLK,
    input  logic            ResetL,
    alu_share_ctrl_if.slave bus
);

    state_t           r_state;
    logic             r_lastGrant;
    logic             r_grantId;
    logic             r_busy;
    logic [WIDTH-1:0] r_aluA;
    logic [WIDTH-1:0] r_aluB;
    logic [CTRLW-1:0] r_aluCtrl;
    logic             r_err;

    logic             r_rspValid0;
    logic [WIDTH-1:0] r_rspW0;
    logic             r_rspZero0;
    logic             r_rspErr0;
    logic             r_rspValid1;
    logic [WIDTH-1:0] r_rspW1;
    logic             r_rspZero1;
    logic             r_rspErr1;

    logic             w_grantValid;
    logic             w_grantId;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept;
    logic [CTRLW-1:0] w_selCtrl;
    logic [WIDTH-1:0] w_resW;
    logic             w_resZero;
    logic             w_rspDone;

    rr_arb2 u_arb (
        .valid0      (bus.Req0Valid),
        .valid1      (bus.Req1Valid),
        .last        (r_lastGrant),
        .grant_valid (w_grantValid),
        .grant_id    (w_grantId)
    );

    assign w_ready0  = (r_state == IDLE) && w_grantValid && !w_grantId;
    assign w_ready1  = (r_state == IDLE) && w_grantValid &&  w_grantId;
    assign w_accept  = (w_ready0 && bus.Req0Valid) || (w_ready1 && bus.Req1Valid);
    assign w_selCtrl = w_grantId ? bus.Req1Ctrl : bus.Req0Ctrl;

    // An illegal opcode never trusts the ALU output
    assign w_resW    = r_err ? '0   : bus.AluBusW;
    assign w_resZero = r_err ? 1'b1 : bus.AluZero;

    assign w_rspDone = r_grantId ? (r_rspValid1 && bus.Rsp1Ready)
                                 : (r_rspValid0 && bus.Rsp0Ready);

    always_ff @(posedge CLK) begin
        if (!ResetL) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_grantId   <= 1'b0;
            r_busy      <= 1'b0;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_aluCtrl   <= '0;
            r_err       <= 1'b0;
            r_rspValid0 <= 1'b0;
            r_rspW0     <= '0;
            r_rspZero0  <= 1'b0;
            r_rspErr0   <= 1'b0;
            r_rspValid1 <= 1'b0;
            r_rspW1     <= '0;
            r_rspZero1  <= 1'b0;
            r_rspErr1   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_aluA      <= w_grantId ? bus.Req1A : bus.Req0A;
                        r_aluB      <= w_grantId ? bus.Req1B : bus.Req0B;
                        r_aluCtrl   <= w_selCtrl;
                        r_grantId   <= w_grantId;
                        r_lastGrant <= w_grantId;
                        r_err       <= !is_legal_op(w_selCtrl);
                        r_busy      <= 1'b1;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_grantId) begin
                        r_rspValid1 <= 1'b1;
                        r_rspW1     <= w_resW;
                        r_rspZero1  <= w_resZero;
                        r_rspErr1   <= r_err;
                    end else begin
                        r_rspValid0 <= 1'b1;
                        r_rspW0     <= w_resW;
                        r_rspZero0  <= w_resZero;
                        r_rspErr0   <= r_err;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    // Result registers are cleared so an idle channel reads 0
                    if (w_rspDone) begin
                        r_rspValid0 <= 1'b0;
                        r_rspW0     <= '0;
                        r_rspZero0  <= 1'b0;
                        r_rspErr0   <= 1'b0;
                        r_rspValid1 <= 1'b0;
                        r_rspW1     <= '0;
                        r_rspZero1  <= 1'b0;
                        r_rspErr1   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Req0Ready = w_ready0;
    assign bus.Req1Ready = w_ready1;
    assign bus.Rsp0Valid = r_rspValid0;
    assign bus.Rsp0W     = r_rspW0;
    assign bus.Rsp0Zero  = r_rspZero0;
    assign bus.Rsp0Err   = r_rspErr0;
    assign bus.Rsp1Valid = r_rspValid1;
    assign bus.Rsp1W     = r_rspW1;
    assign bus.Rsp1Zero  = r_rspZero1;
    assign bus.Rsp1Err   = r_rspErr1;
    assign bus.AluBusA   = r_aluA;
    assign bus.AluBusB   = r_aluB;
    assign bus.AluCtrl   = r_aluCtrl;
    assign bus.Busy      = r_busy;
    assign bus.GrantId   = r_grantId;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_share_ctrl
// Brief   : Self-checking bench for alu_share_ctrl with an external ALU model
//           and a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_share_ctrl;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  c;
    } op_t;

    typedef struct {
        logic        id;
        logic [63:0] w;
        logic        z;
        logic        e;
    } rsp_t;

    logic clk    = 1'b0;
    logic resetL = 1'b0;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.WIDTH(64), .CTRLW(4)) bus ();

    alu_share_ctrl #(.WIDTH(64), .CTRLW(4)) dut (
        .CLK    (clk),
        .ResetL (resetL),
        .bus    (bus)
    );

    function automatic logic [63:0] aluFn(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] c);
        case (c)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            4'h7:    return b;
            default: return 64'hDEAD_BEEF_0BAD_F00D;
        endcase
    endfunction

    function automatic logic legalOp(input logic [3:0] c);
        return (c == 4'h0) || (c == 4'h1) || (c == 4'h2) || (c == 4'h6) || (c == 4'h7);
    endfunction

    // External combinational ALU
    assign bus.AluBusW = aluFn(bus.AluBusA, bus.AluBusB, bus.AluCtrl);
    assign bus.AluZero = (bus.AluBusW == 64'd0);

    int   vectors     = 0;
    int   miscompares = 0;
    op_t  q0[$];
    op_t  q1[$];
    logic acc0 = 1'b0;
    logic acc1 = 1'b0;
    rsp_t rspLog[$];
    logic grantLog[$];

    // Transaction-level reference state
    logic        mOut  = 1'b0;
    logic        mGrant = 1'b0;
    logic        mLast = 1'b1;
    int          mK    = 0;
    logic [63:0] mA    = '0;
    logic [63:0] mB    = '0;
    logic [3:0]  mC    = '0;
    logic [63:0] mW    = '0;
    logic        mZ    = 1'b0;
    logic        mE    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkRsp(input string name, input int idx, input logic id,
                          input logic [63:0] w, input logic z, input logic e);
        if (idx >= rspLog.size()) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: response %0d missing, got %0d responses", name, idx, rspLog.size());
        end else begin
            chk({name, "_id"}, 64'(rspLog[idx].id), 64'(id));
            chk({name, "_W"},  rspLog[idx].w, w);
            chk({name, "_Z"},  64'(rspLog[idx].z), 64'(z));
            chk({name, "_E"},  64'(rspLog[idx].e), 64'(e));
        end
    endtask

    task automatic chkGrant(input string name, input int idx, input logic id);
        if (idx >= grantLog.size()) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: grant %0d missing, got %0d grants", name, idx, grantLog.size());
        end else begin
            chk(name, 64'(grantLog[idx]), 64'(id));
        end
    endtask

    // Per-cycle compare against the reference, then advance it across the next edge
    initial begin
        @(posedge clk);
        forever begin
            logic winValid, win, ev0, ev1, lg;
            logic [63:0] a, b;
            logic [3:0]  c;
            @(negedge clk);
            chk("Busy",    64'(bus.Busy), 64'(mOut));
            chk("GrantId", 64'(bus.GrantId), 64'(mGrant));
            chk("AluBusA", bus.AluBusA, mA);
            chk("AluBusB", bus.AluBusB, mB);
            chk("AluCtrl", 64'(bus.AluCtrl), 64'(mC));
            winValid = bus.Req0Valid | bus.Req1Valid;
            win      = (bus.Req0Valid && bus.Req1Valid) ? !mLast : bus.Req1Valid;
            chk("Req0Ready", 64'(bus.Req0Ready), 64'(!mOut && winValid && !win));
            chk("Req1Ready", 64'(bus.Req1Ready), 64'(!mOut && winValid && win));
            ev0 = mOut && !mGrant && (mK >= 2);
            ev1 = mOut &&  mGrant && (mK >= 2);
            chk("Rsp0Valid", 64'(bus.Rsp0Valid), 64'(ev0));
            chk("Rsp0W",     bus.Rsp0W, ev0 ? mW : 64'd0);
            chk("Rsp0Zero",  64'(bus.Rsp0Zero), 64'(ev0 && mZ));
            chk("Rsp0Err",   64'(bus.Rsp0Err),  64'(ev0 && mE));
            chk("Rsp1Valid", 64'(bus.Rsp1Valid), 64'(ev1));
            chk("Rsp1W",     bus.Rsp1W, ev1 ? mW : 64'd0);
            chk("Rsp1Zero",  64'(bus.Rsp1Zero), 64'(ev1 && mZ));
            chk("Rsp1Err",   64'(bus.Rsp1Err),  64'(ev1 && mE));

            if (!resetL) begin
                mOut = 1'b0; mGrant = 1'b0; mLast = 1'b1; mK = 0;
                mA = '0; mB = '0; mC = '0;
            end else if (mOut) begin
                if ((ev0 && bus.Rsp0Ready) || (ev1 && bus.Rsp1Ready)) begin
                    rspLog.push_back('{mGrant, mW, mZ, mE});
                    mOut = 1'b0;
                end else if (mK < 1000) begin
                    mK++;
                end
            end else if (winValid) begin
                a  = win ? bus.Req1A : bus.Req0A;
                b  = win ? bus.Req1B : bus.Req0B;
                c  = win ? bus.Req1Ctrl : bus.Req0Ctrl;
                lg = legalOp(c);
                mA = a; mB = b; mC = c;
                mOut = 1'b1; mK = 1; mGrant = win; mLast = win;
                mW = lg ? aluFn(a, b, c) : 64'd0;
                mZ = lg ? (aluFn(a, b, c) == 64'd0) : 1'b1;
                mE = !lg;
                grantLog.push_back(win);
                if (win) acc1 = 1'b1; else acc0 = 1'b1;
            end
        end
    end

    // Requester drivers: present queue heads, advance after each acceptance
    initial begin
        bus.Req0Valid = 1'b0; bus.Req0A = '0; bus.Req0B = '0; bus.Req0Ctrl = '0;
        bus.Req1Valid = 1'b0; bus.Req1A = '0; bus.Req1B = '0; bus.Req1Ctrl = '0;
        bus.Rsp0Ready = 1'b1; bus.Rsp1Ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (acc0) begin q0.delete(0); acc0 = 1'b0; end
            if (acc1) begin q1.delete(0); acc1 = 1'b0; end
            if (q0.size() > 0) begin
                bus.Req0Valid = 1'b1; bus.Req0A = q0[0].a; bus.Req0B = q0[0].b; bus.Req0Ctrl = q0[0].c;
            end else begin
                bus.Req0Valid = 1'b0;
            end
            if (q1.size() > 0) begin
                bus.Req1Valid = 1'b1; bus.Req1A = q1[0].a; bus.Req1B = q1[0].b; bus.Req1Ctrl = q1[0].c;
            end else begin
                bus.Req1Valid = 1'b0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || mOut) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s: not drained, %0d cycles used, limit %0d", name, n, budget);
        end
    endtask

    task automatic newTest();
        rspLog.delete();
        grantLog.delete();
    endtask

    initial begin
        int n;
        resetL = 1'b0;
        cycles(3);
        resetL = 1'b1;
        @(negedge clk);
        chk("rst_Busy",      64'(bus.Busy), 64'd0);
        chk("rst_GrantId",   64'(bus.GrantId), 64'd0);
        chk("rst_AluBusA",   bus.AluBusA, 64'd0);
        chk("rst_Rsp0Valid", 64'(bus.Rsp0Valid), 64'd0);

        // R0 alone: ADD
        cycles(1); newTest();
        q0.push_back('{64'h69, 64'h420, 4'h2});
        waitDrain("t1_drain", 20);
        chkRsp("t1", 0, 1'b0, 64'h489, 1'b0, 1'b0);

        // Both valid straight out of reset
        resetL = 1'b0; cycles(2); resetL = 1'b1; newTest();
        q0.push_back('{64'hFFFF, 64'hFFFF, 4'h6});
        q1.push_back('{64'h7382, 64'h1F1F, 4'h0});
        waitDrain("t2_drain", 30);
        chkGrant("t2_g0", 0, 1'b0);
        chkGrant("t2_g1", 1, 1'b1);
        chkRsp("t2_r0", 0, 1'b0, 64'h0, 1'b1, 1'b0);
        chkRsp("t2_r1", 1, 1'b1, 64'h1302, 1'b0, 1'b0);

        // Continuous contention, four operations
        newTest();
        q0.push_back('{64'd1, 64'd2, 4'h2});
        q0.push_back('{64'd10, 64'd20, 4'h2});
        q1.push_back('{64'd100, 64'd1, 4'h6});
        q1.push_back('{64'd5, 64'h55, 4'h7});
        waitDrain("t3_drain", 60);
        chkGrant("t3_g0", 0, 1'b0);
        chkGrant("t3_g1", 1, 1'b1);
        chkGrant("t3_g2", 2, 1'b0);
        chkGrant("t3_g3", 3, 1'b1);
        chkRsp("t3_r0", 0, 1'b0, 64'd3,   1'b0, 1'b0);
        chkRsp("t3_r1", 1, 1'b1, 64'd99,  1'b0, 1'b0);
        chkRsp("t3_r2", 2, 1'b0, 64'd30,  1'b0, 1'b0);
        chkRsp("t3_r3", 3, 1'b1, 64'h55,  1'b0, 1'b0);

        // Illegal opcode from R1
        newTest();
        q1.push_back('{64'hBABE, 64'h1, 4'h3});
        waitDrain("t4_drain", 20);
        chkRsp("t4", 0, 1'b1, 64'h0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t4_idleBusy", 64'(bus.Busy), 64'd0);

        // Backpressure on R0 with R1 waiting
        cycles(1); newTest();
        bus.Rsp0Ready = 1'b0;
        q0.push_back('{64'h1248, 64'h8421, 4'h1});
        q1.push_back('{64'd5, 64'd6, 4'h2});
        n = 0;
        @(negedge clk);
        while (!bus.Rsp0Valid && n < 10) begin @(negedge clk); n++; end
        chk("t5_validSeen", 64'(bus.Rsp0Valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(bus.Rsp0Valid), 64'd1);
            chk("t5_hold_W",     bus.Rsp0W, 64'h9669);
            chk("t5_hold_busy",  64'(bus.Busy), 64'd1);
            chk("t5_hold_r1rdy", 64'(bus.Req1Ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.Rsp0Ready = 1'b1;
        waitDrain("t5_drain", 30);
        chkGrant("t5_g0", 0, 1'b0);
        chkGrant("t5_g1", 1, 1'b1);
        chkRsp("t5_r0", 0, 1'b0, 64'h9669, 1'b0, 1'b0);
        chkRsp("t5_r1", 1, 1'b1, 64'd11,   1'b0, 1'b0);

        // Reset while an operation is in EXEC
        newTest();
        q0.push_back('{64'h0, 64'h8_2299_3167, 4'h7});
        n = 0;
        while (grantLog.size() == 0 && n < 20) begin @(negedge clk); n++; end
        chk("t6_accepted", 64'(grantLog.size()), 64'd1);
        @(posedge clk); #1;
        resetL = 1'b0;
        @(posedge clk); #1;
        resetL = 1'b1;
        @(negedge clk);
        chk("t6_busy",      64'(bus.Busy), 64'd0);
        chk("t6_rsp0Valid", 64'(bus.Rsp0Valid), 64'd0);
        chk("t6_rsp1Valid", 64'(bus.Rsp1Valid), 64'd0);
        chk("t6_noRsp",     64'(rspLog.size()), 64'd0);
        cycles(1); newTest();
        q0.push_back('{64'd7, 64'd8, 4'h2});
        q1.push_back('{64'd1, 64'd1, 4'h2});
        waitDrain("t6_drain", 30);
        chkGrant("t6_g0", 0, 1'b0);
        chkGrant("t6_g1", 1, 1'b1);
        chkRsp("t6_r0", 0, 1'b0, 64'd15, 1'b0, 1'b0);
        chkRsp("t6_r1", 1, 1'b1, 64'd2,  1'b0, 1'b0);

        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares",
                 vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
